hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and redirect controller for the 16-bit five-stage core (IF, ID, EX, MEM, WB). It sits beside the decode and execute stages. Each cycle it inspects the instruction in ID against the in-flight producers in EX, MEM and WB, and drives operand-forward selects, IF/ID stalls and an EX bubble. When EX resolves a taken jump, it sequences the flush/redirect. It also keeps saturating stall and flush event counters.

## Interface
Parameters:
- CNT_W, 16, width of the event counters

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_op  in  4  ID opcode
- id_rs1, id_rs2  in  5 each  ID source indices
- ex_valid, ex_we  in  1 each  EX instruction valid / writes a register
- ex_op  in  4  EX opcode
- ex_rd  in  5  EX destination
- mem_valid, mem_we  in  1 each  MEM valid / write
- mem_rd  in  5  MEM destination
- wb_valid, wb_we  in  1 each  WB valid / write
- wb_rd  in  5  WB destination
- ex_br_taken  in  1  jump in EX is taken this cycle
- stall_if, stall_id  out  1 each  hold the PC and the IF/ID latch
- bubble_ex  out  1  insert a NOP into the ID/EX latch
- flush_id  out  1  squash the IF/ID latch
- pc_sel  out  1  the PC loads the registered jump target
- fwd_a, fwd_b  out  2 each  operand source: 00 register file, 01 EX result, 10 MEM output, 11 WB data
- stall_cnt, flush_cnt  out  CNT_W each  event counters

## Operation
- Source use is decoded from id_op:
  - rs1 is read by SUB, ADD, ADDI, SHLLI, SHRLI, CMP, STORE.
  - rs2 is read by SUB, ADD, CMP, JUMP, STORE, MOV.
  - Other opcodes never cause a hazard.
- A producer matches a source when the producer is valid, has its write bit set, its rd equals the source index, and the source is used.
- Forwarding picks the youngest match: EX over MEM over WB. If nothing matches, the select is 00. Index 0 is an ordinary register.
- Load-use: ex_op == LOAD and the EX instruction matches a used source. In that cycle stall_if=stall_id=bubble_ex=1 and the fwd selects are don't-care.
- FSM states: RUN, LDSTALL, REDIRECT. Reset state is RUN.
  - RUN → LDSTALL on load-use. RUN → REDIRECT on ex_br_taken.
  - LDSTALL lasts exactly 1 cycle, then RUN. The held consumer now sees the LOAD in MEM and gets fwd=10.
  - REDIRECT lasts 1 cycle, then RUN.
- Taken jump in cycle N (any state):
  - Cycle N: flush_id=1 and bubble_ex=1, killing the two younger instructions. Stalls are forced to 0.
  - Cycle N+1 (REDIRECT): pc_sel=1, because the registered target is valid now. flush_id=1 squashes the wrong-path fetch from N.
- Simultaneous events: ex_br_taken beats load-use, since the stalled consumer is wrong-path. ex_br_taken arriving while in REDIRECT is ignored.
- Counters saturate at all-ones:
  - stall_cnt increments once per cycle with stall_id=1.
  - flush_cnt increments once per taken jump.
- Opcode encoding: NOP 0, SUB 1, ADD 2, ADDI 3, SHLLI 4, SHRLI 5, JUMP 6, JUMPL 7, JUMPG 8, JUMPE 9, JUMPNE A, CMP B, LOAD C, LOADI D, STORE E, MOV F.

## Timing
- Stall, bubble, flush and fwd outputs are combinational from the current inputs and state. Zero latency.
- pc_sel, the state register and the counters are registered.
- Reset values, taking effect at the first clk edge with rst=1:
  - State is RUN and all counters are 0.
  - While rst=1, all stall, bubble, flush and pc_sel outputs are forced to 0 and fwd outputs to 00.
- Reset mid-REDIRECT or mid-LDSTALL abandons the sequence. No pc_sel is issued after reset.
- Load-use costs 1 bubble. A taken jump costs 2 squashed slots plus 1 redirect cycle.

## Configuration
- FORWARDING_EN defined: behaviour as described above.
- FORWARDING_EN undefined:
  - fwd_a and fwd_b are tied to 00.
  - Any source match in EX, MEM or WB asserts stall_if=stall_id=bubble_ex=1. The stall persists until no match remains, up to 3 cycles.
  - The LDSTALL state is unused.

## Structure
- The shared package core_pkg holds the opcode constants, the FWD_* select encodings and the FSM state enum. Execute and decode share it.
- One sub-module, hazard_match: a combinational source-use decode plus producer compare, instantiated once per source operand.

## Test plan
- ADD r3 in EX, SUB reading r3 in ID → fwd_a=01, no stall.
- r3 written in MEM and in WB, consumer reads r3 → fwd=10, because the younger producer wins.
- LOAD r4 in EX, ADD r4,r5 in ID → stall_if/stall_id/bubble_ex=1 for one cycle, then fwd_a=10. stall_cnt=1.
- ex_br_taken pulse while a load-use is also present → flush_id=1 and bubble_ex=1 with no stall, next cycle pc_sel=1. flush_cnt=1.
- rst asserted during REDIRECT → next cycle pc_sel=0 and state RUN. Counters 0.
- Build without FORWARDING_EN, producer r2 in EX, consumer r2 in ID → stall held 3 cycles, released when the producer leaves WB.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, forward-select encodings, hazard FSM states
// and the operand-use decode used by decode, execute and the hazard controller.
package core_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_ADDI   = 4'h3;
  localparam logic [3:0] OP_SHLLI  = 4'h4;
  localparam logic [3:0] OP_SHRLI  = 4'h5;
  localparam logic [3:0] OP_JUMP   = 4'h6;
  localparam logic [3:0] OP_JUMPL  = 4'h7;
  localparam logic [3:0] OP_JUMPG  = 4'h8;
  localparam logic [3:0] OP_JUMPE  = 4'h9;
  localparam logic [3:0] OP_JUMPNE = 4'hA;
  localparam logic [3:0] OP_CMP    = 4'hB;
  localparam logic [3:0] OP_LOAD   = 4'hC;
  localparam logic [3:0] OP_LOADI  = 4'hD;
  localparam logic [3:0] OP_STORE  = 4'hE;
  localparam logic [3:0] OP_MOV    = 4'hF;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LDSTALL,
    ST_REDIRECT
  } state_e;

  function automatic logic uses_rs1(input logic [3:0] op);
    case (op)
      OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI, OP_CMP, OP_STORE: uses_rs1 = 1'b1;
      default: uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [3:0] op);
    case (op)
      OP_SUB, OP_ADD, OP_CMP, OP_JUMP, OP_STORE, OP_MOV: uses_rs2 = 1'b1;
      default: uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand hazard compare: decodes whether the ID opcode reads this source
// and flags which in-flight producers (EX, MEM, WB) write it.
module hazard_match
  import core_pkg::*;
#(
  parameter bit IS_RS2 = 1'b0
) (
  input  logic       id_valid_i,
  input  logic [3:0] op_i,
  input  logic [4:0] src_i,
  input  logic       ex_valid_i,
  input  logic       ex_we_i,
  input  logic [4:0] ex_rd_i,
  input  logic       mem_valid_i,
  input  logic       mem_we_i,
  input  logic [4:0] mem_rd_i,
  input  logic       wb_valid_i,
  input  logic       wb_we_i,
  input  logic [4:0] wb_rd_i,
  output logic       ex_hit_o,
  output logic       mem_hit_o,
  output logic       wb_hit_o
);

  logic used;

  always_comb begin
    used      = id_valid_i && (IS_RS2 ? uses_rs2(op_i) : uses_rs1(op_i));
    ex_hit_o  = used && ex_valid_i  && ex_we_i  && (ex_rd_i  == src_i);
    mem_hit_o = used && mem_valid_i && mem_we_i && (mem_rd_i == src_i);
    wb_hit_o  = used && wb_valid_i  && wb_we_i  && (wb_rd_i  == src_i);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/redirect controller: forward selects, load-use stalls, jump flush and
// redirect sequencing, saturating event counters. Forwarding under FORWARDING_EN.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_op,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_valid,
  input  logic             ex_we,
  input  logic [3:0]       ex_op,
  input  logic [4:0]       ex_rd,
  input  logic             mem_valid,
  input  logic             mem_we,
  input  logic [4:0]       mem_rd,
  input  logic             wb_valid,
  input  logic             wb_we,
  input  logic [4:0]       wb_rd,
  input  logic             ex_br_taken,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             pc_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

`ifdef FORWARDING_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             a_ex, a_mem, a_wb, b_ex, b_mem, b_wb;
  logic             load_use, hazard, taken, stall;
  logic [1:0]       sel_a, sel_b;

  hazard_match #(.IS_RS2(1'b0)) u_match_a (
    .id_valid_i(id_valid), .op_i(id_op), .src_i(id_rs1),
    .ex_valid_i(ex_valid), .ex_we_i(ex_we), .ex_rd_i(ex_rd),
    .mem_valid_i(mem_valid), .mem_we_i(mem_we), .mem_rd_i(mem_rd),
    .wb_valid_i(wb_valid), .wb_we_i(wb_we), .wb_rd_i(wb_rd),
    .ex_hit_o(a_ex), .mem_hit_o(a_mem), .wb_hit_o(a_wb)
  );

  hazard_match #(.IS_RS2(1'b1)) u_match_b (
    .id_valid_i(id_valid), .op_i(id_op), .src_i(id_rs2),
    .ex_valid_i(ex_valid), .ex_we_i(ex_we), .ex_rd_i(ex_rd),
    .mem_valid_i(mem_valid), .mem_we_i(mem_we), .mem_rd_i(mem_rd),
    .wb_valid_i(wb_valid), .wb_we_i(wb_we), .wb_rd_i(wb_rd),
    .ex_hit_o(b_ex), .mem_hit_o(b_mem), .wb_hit_o(b_wb)
  );

  always_comb begin
    load_use = (ex_op == OP_LOAD) && (a_ex || b_ex);
    sel_a    = a_ex ? FWD_EX : a_mem ? FWD_MEM : a_wb ? FWD_WB : FWD_RF;
    sel_b    = b_ex ? FWD_EX : b_mem ? FWD_MEM : b_wb ? FWD_WB : FWD_RF;
`ifdef FORWARDING_EN
    hazard   = load_use;
`else
    // load_use is a subset of any match; OR-ing it in keeps ex_op observed
    hazard   = a_ex || a_mem || a_wb || b_ex || b_mem || b_wb || load_use;
    sel_a    = FWD_RF;
    sel_b    = FWD_RF;
`endif
    // A jump seen while already redirecting is a squashed slot; ID is being
    // flushed in REDIRECT, so stalling it would only waste a cycle.
    taken    = ex_br_taken && (state_q != ST_REDIRECT);
    stall    = hazard && !taken && (state_q != ST_REDIRECT);

    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    pc_sel    = 1'b0;
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    if (!rst) begin
      stall_if  = stall;
      stall_id  = stall;
      bubble_ex = stall || taken;
      flush_id  = taken || (state_q == ST_REDIRECT);
      pc_sel    = (state_q == ST_REDIRECT);
      fwd_a     = sel_a;
      fwd_b     = sel_b;
    end

    state_d = ST_RUN;
    case (state_q)
      ST_RUN:      state_d = taken ? ST_REDIRECT : (stall && FwdEn) ? ST_LDSTALL : ST_RUN;
      ST_LDSTALL:  state_d = taken ? ST_REDIRECT : ST_RUN;
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_id && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (taken && (flush_cnt_q != '1))    flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
